mem_req_sequencer: RTL and testbench
====================================

MEM_REQ_SEQUENCER -- requirements
Module: mem_req_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of 2, >=2).
REQ-002 SHALL have port CLK  in  1  system clock, all state updates on posedge.
REQ-003 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  upstream command valid.
REQ-005 SHALL have port req_ready  out  1  command FIFO can accept.
REQ-006 SHALL have port req_wr  in  1  1=write, 0=read.
REQ-007 SHALL have port req_addr  in  4  word address.
REQ-008 SHALL have port req_data  in  32  write data (ignored for reads).
REQ-009 SHALL have port mem_en  out  1  memory enable, one-cycle pulse per issued command.
REQ-010 SHALL have port mem_w_r  out  1  1=write, 0=read, to memory.
REQ-011 SHALL have port mem_addr  out  4  memory address.
REQ-012 SHALL have port mem_data_in  out  32  memory write data.
REQ-013 SHALL have port mem_data_out  in  32  memory read data, registered by memory one edge after a read issue.
REQ-014 SHALL have port mem_valid_out  in  1  memory read-valid flag.
REQ-015 SHALL have port rsp_valid  out  1  read response valid.
REQ-016 SHALL have port rsp_ready  in  1  downstream accepts response.
REQ-017 SHALL have port rsp_data  out  32  read data.
REQ-018 SHALL have port rsp_addr  out  4  address of the read.
REQ-019 SHALL have port idle  out  1  FIFO empty, no read in flight, no response held.
REQ-020 SHALL have port err  out  1  sticky: capture cycle saw mem_valid_out=0.

Function
REQ-021 SHALL push {wr,addr,data} into FIFO on posedge when req_valid && req_ready.
REQ-022 SHALL drive req_ready = !full, independent of same-cycle pop (full FIFO never accepts, even when popping).
REQ-023 SHALL use FSM states ISSUE, RD_WAIT, RSP_HOLD; ISSUE after reset.
REQ-024 ISSUE, FIFO non-empty, head=write: SHALL pop and drive mem_en=1, mem_w_r=1, head addr/data combinationally that cycle; stay ISSUE (back-to-back writes, 1/cycle).
REQ-025 ISSUE, head=read: SHALL pop, drive mem_en=1, mem_w_r=0, mem_addr=head addr, latch addr; go RD_WAIT.
REQ-026 RD_WAIT (exactly one cycle): SHALL drive mem_en=0, capture mem_data_out into rsp_data and latched addr into rsp_addr at its closing edge, set rsp_valid=1, set err if mem_valid_out=0; go RSP_HOLD.
REQ-027 Read latency SHALL be: request accepted cycle A, issued A+1, rsp_valid first high A+3 (empty FIFO, rsp_ready=1).
REQ-028 RSP_HOLD: rsp_valid=1, rsp_data/rsp_addr stable until rsp_valid && rsp_ready edge; then clear rsp_valid, go ISSUE.
REQ-029 RSP_HOLD with head=write: SHALL issue write as in REQ-024 while holding response; head=read SHALL stall (mem_en=0, no pop).
REQ-030 RSP_HOLD, rsp_ready=1 and head=read same cycle: SHALL NOT issue the read that cycle; issue next cycle from ISSUE.
REQ-031 FIFO empty in ISSUE/RSP_HOLD: mem_en=0; mem_w_r, mem_addr, mem_data_in SHALL be 0 whenever mem_en=0.
REQ-032 Simultaneous push and pop, non-full FIFO: both SHALL occur, occupancy unchanged; pointers wrap modulo DEPTH.
REQ-033 Commands SHALL issue strictly in acceptance order; at most one read outstanding.
REQ-034 err SHALL stay 1 until reset.

Reset
REQ-035 RST=1 SHALL immediately (async) empty FIFO, FSM to ISSUE, and force req_ready=0, mem_en=0, mem_w_r=0, mem_addr=0, mem_data_in=0, rsp_valid=0, rsp_data=0, rsp_addr=0, err=0, idle=1.
REQ-036 RST during RD_WAIT/RSP_HOLD SHALL discard the pending read with no response; req_ready=1 first cycle after release.

Verification
REQ-037 Write 0xDEADBEEF@3 then read @3, rsp_ready=1 -> mem_en pulses on cycles A+1,A+2; rsp_valid=1 with rsp_data=0xDEADBEEF, rsp_addr=3.
REQ-038 Push 4 writes, no pops possible (hold RST-free, keep FIFO full by stalling with held rsp + read at head) -> req_ready=0 on 5th, 5th command not accepted.
REQ-039 Read @5 with rsp_ready=0 for 3 cycles, then write @7 queued -> write issues during RSP_HOLD, rsp_data unchanged, rsp drops 1 cycle after rsp_ready=1.
REQ-040 mem_valid_out tied 0 during one read -> err=1, remains 1 after further reads; rsp still delivered.
REQ-041 Assert RST in RD_WAIT -> rsp_valid never rises, all outputs 0, idle=1; post-release read @0 returns 0.
REQ-042 Stream 10 alternating writes/reads to addresses 0..4 wrapping pointers -> responses in order, data matches last written values.

Source files
------------

// File: rtl/mem_req_sequencer.sv
// Command sequencer: queues write/read commands in a FIFO and issues them to a
// single-port memory, holding one read response at a time for the downstream side.
module mem_req_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_data,
    output logic        mem_en,
    output logic        mem_w_r,
    output logic [3:0]  mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_valid_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_addr,
    output logic        idle,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ISSUE,
        RD_WAIT,
        RSP_HOLD
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   r_wrPtr;
    logic [AW:0]   r_rdPtr;
    logic          r_fifoWr   [DEPTH];
    logic [3:0]    r_fifoAddr [DEPTH];
    logic [31:0]   r_fifoData [DEPTH];

    logic [3:0]    r_pendAddr;
    logic [31:0]   r_rspData;
    logic [3:0]    r_rspAddr;
    logic          r_err;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_latchAddr;
    logic          w_headWr;
    logic [3:0]    w_headAddr;
    logic [31:0]   w_headData;

    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                        (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_headWr   = r_fifoWr[r_rdPtr[AW-1:0]];
    assign w_headAddr = r_fifoAddr[r_rdPtr[AW-1:0]];
    assign w_headData = r_fifoData[r_rdPtr[AW-1:0]];

    // Ready ignores a same-cycle pop; it is also held low while reset is asserted.
    assign req_ready = !RST && !w_full;
    assign w_push    = req_valid && req_ready;

    assign rsp_valid = (r_state == RSP_HOLD);
    assign rsp_data  = r_rspData;
    assign rsp_addr  = r_rspAddr;
    assign err       = r_err;
    assign idle      = w_empty && (r_state == ISSUE);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifoWr[r_wrPtr[AW-1:0]]   <= req_wr;
            r_fifoAddr[r_wrPtr[AW-1:0]] <= req_addr;
            r_fifoData[r_wrPtr[AW-1:0]] <= req_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

    // Writes may issue while a response is held; reads wait until it is released.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_latchAddr = 1'b0;
        mem_en      = 1'b0;
        mem_w_r     = 1'b0;
        mem_addr    = 4'd0;
        mem_data_in = 32'd0;
        case (r_state)
            ISSUE: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = w_headAddr;
                    if (w_headWr) begin
                        mem_w_r     = 1'b1;
                        mem_data_in = w_headData;
                    end else begin
                        w_latchAddr = 1'b1;
                        w_nextState = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                w_nextState = RSP_HOLD;
            end
            RSP_HOLD: begin
                if (!w_empty && w_headWr) begin
                    w_pop       = 1'b1;
                    mem_en      = 1'b1;
                    mem_w_r     = 1'b1;
                    mem_addr    = w_headAddr;
                    mem_data_in = w_headData;
                end
                if (rsp_ready) begin
                    w_nextState = ISSUE;
                end
            end
            default: begin
                w_nextState = ISSUE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ISSUE;
            r_pendAddr <= 4'd0;
            r_rspData  <= 32'd0;
            r_rspAddr  <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_latchAddr) begin
                r_pendAddr <= w_headAddr;
            end
            if (r_state == RD_WAIT) begin
                r_rspData <= mem_data_out;
                r_rspAddr <= r_pendAddr;
                if (!mem_valid_out) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed testbench for mem_req_sequencer with a small registered memory model
// and monitors that log issued commands and delivered responses.
module tb_mem_req_sequencer;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [3:0]  req_addr;
    logic [31:0] req_data;
    logic        mem_en;
    logic        mem_w_r;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_valid_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_addr;
    logic        idle;
    logic        err;

    int testsRun;
    int testsFailed;

    logic [31:0] memModel [16];
    logic        forceInvalid;

    int          issCount;
    logic [3:0]  issAddr [64];
    logic        issWr   [64];
    int          rspCount;
    logic [3:0]  rspAddrLog [64];
    logic [31:0] rspDataLog [64];

    mem_req_sequencer #(.DEPTH(4)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .mem_en       (mem_en),
        .mem_w_r      (mem_w_r),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_valid_out(mem_valid_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_addr     (rsp_addr),
        .idle         (idle),
        .err          (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory registers read data and its valid flag on the edge that issues the read.
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_w_r) begin
                memModel[mem_addr] <= mem_data_in;
            end else begin
                mem_data_out  <= memModel[mem_addr];
                mem_valid_out <= !forceInvalid;
            end
        end
    end

    always begin
        @(negedge CLK);
        #2;
        if (mem_en && issCount < 64) begin
            issAddr[issCount] = mem_addr;
            issWr[issCount]   = mem_w_r;
            issCount++;
        end
        if (rsp_valid && rsp_ready && rspCount < 64) begin
            rspAddrLog[rspCount] = rsp_addr;
            rspDataLog[rspCount] = rsp_data;
            rspCount++;
        end
    end

    task automatic nextCycle;
        @(negedge CLK);
    endtask

    task automatic waitIdle;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            nextCycle();
            #1;
            if (idle) break;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        nextCycle();
        #1;
        testsRun++;
        if (req_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_req_ready: got %0b want 0", req_ready); end
        testsRun++;
        if (mem_en !== 1'b0 || mem_addr !== 4'd0 || mem_data_in !== 32'd0) begin
            testsFailed++; $display("[TB] FAIL reset_mem_if: en=%0b addr=%0h data=%0h want all 0", mem_en, mem_addr, mem_data_in);
        end
        testsRun++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_addr !== 4'd0) begin
            testsFailed++; $display("[TB] FAIL reset_rsp: valid=%0b data=%0h addr=%0h want all 0", rsp_valid, rsp_data, rsp_addr);
        end
        testsRun++;
        if (idle !== 1'b1 || err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_idle_err: idle=%0b err=%0b want 1/0", idle, err); end
        nextCycle();
        RST = 1'b0;
        #1;
        testsRun++;
        if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_release_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_write_read;
        waitIdle();
        nextCycle();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd3; req_data = 32'hDEADBEEF;
        #1;
        testsRun++;
        if (mem_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_before_issue: mem_en=%0b want 0", mem_en); end
        nextCycle();
        req_wr = 1'b0; req_data = 32'h0;
        #1;
        testsRun++;
        if (mem_en !== 1'b1 || mem_w_r !== 1'b1 || mem_addr !== 4'd3 || mem_data_in !== 32'hDEADBEEF) begin
            testsFailed++; $display("[TB] FAIL wr_issue: en=%0b w_r=%0b addr=%0h data=%0h want 1 1 3 deadbeef", mem_en, mem_w_r, mem_addr, mem_data_in);
        end
        nextCycle();
        req_valid = 1'b0;
        #1;
        testsRun++;
        if (mem_en !== 1'b1 || mem_w_r !== 1'b0 || mem_addr !== 4'd3) begin
            testsFailed++; $display("[TB] FAIL rd_issue: en=%0b w_r=%0b addr=%0h want 1 0 3", mem_en, mem_w_r, mem_addr);
        end
        nextCycle();
        #1;
        testsRun++;
        if (mem_en !== 1'b0 || rsp_valid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL rd_wait: en=%0b rsp_valid=%0b want 0 0", mem_en, rsp_valid);
        end
        nextCycle();
        #1;
        testsRun++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_addr !== 4'd3) begin
            testsFailed++; $display("[TB] FAIL rd_rsp: valid=%0b data=%0h addr=%0h want 1 deadbeef 3", rsp_valid, rsp_data, rsp_addr);
        end
        nextCycle();
        #1;
        testsRun++;
        if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL rd_done: valid=%0b idle=%0b want 0 1", rsp_valid, idle);
        end
    endtask

    task automatic test_fifo_full;
        int base;
        waitIdle();
        base = issCount;
        nextCycle();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd1; req_data = 32'h0;
        nextCycle();
        req_addr = 4'd2;
        nextCycle();
        req_wr = 1'b1; req_addr = 4'd4; req_data = 32'h44;
        nextCycle();
        req_addr = 4'd5; req_data = 32'h55;
        nextCycle();
        req_addr = 4'd6; req_data = 32'h66;
        #1;
        testsRun++;
        if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_fourth_ready: got %0b want 1", req_ready); end
        nextCycle();
        req_addr = 4'd7; req_data = 32'h77;
        #1;
        testsRun++;
        if (req_ready !== 1'b0 || mem_en !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL full_fifth_ready: ready=%0b mem_en=%0b want 0 0", req_ready, mem_en);
        end
        nextCycle();
        #1;
        testsRun++;
        if (req_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_hold_ready: got %0b want 0", req_ready); end
        nextCycle();
        req_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        testsRun++;
        if (rsp_valid !== 1'b1 || rsp_addr !== 4'd1 || rsp_data !== 32'd0 || mem_en !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL full_release: valid=%0b addr=%0h data=%0h en=%0b want 1 1 0 0", rsp_valid, rsp_addr, rsp_data, mem_en);
        end
        nextCycle();
        #1;
        testsRun++;
        if (mem_en !== 1'b1 || mem_w_r !== 1'b0 || mem_addr !== 4'd2 || req_ready !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL full_next_read: en=%0b w_r=%0b addr=%0h ready=%0b want 1 0 2 0", mem_en, mem_w_r, mem_addr, req_ready);
        end
        repeat (8) nextCycle();
        #3;
        testsRun++;
        if (issCount - base !== 5) begin
            testsFailed++; $display("[TB] FAIL full_issue_count: got %0d want 5", issCount - base);
        end else begin
            testsRun++;
            if (issAddr[base+4] !== 4'd6 || issWr[base+4] !== 1'b1 || issAddr[base+2] !== 4'd4) begin
                testsFailed++; $display("[TB] FAIL full_issue_order: last=%0h third=%0h want 6 4", issAddr[base+4], issAddr[base+2]);
            end
        end
    endtask

    task automatic test_rsp_hold_write;
        waitIdle();
        nextCycle();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd5; req_data = 32'h55AA0005;
        nextCycle();
        req_wr = 1'b0; req_data = 32'h0;
        nextCycle();
        req_valid = 1'b0;
        nextCycle();
        nextCycle();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd7; req_data = 32'h00007777;
        #1;
        testsRun++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h55AA0005 || rsp_addr !== 4'd5) begin
            testsFailed++; $display("[TB] FAIL hold_rsp: valid=%0b data=%0h addr=%0h want 1 55aa0005 5", rsp_valid, rsp_data, rsp_addr);
        end
        nextCycle();
        req_valid = 1'b0;
        #1;
        testsRun++;
        if (mem_en !== 1'b1 || mem_w_r !== 1'b1 || mem_addr !== 4'd7 || mem_data_in !== 32'h00007777) begin
            testsFailed++; $display("[TB] FAIL hold_write_issue: en=%0b w_r=%0b addr=%0h data=%0h want 1 1 7 7777", mem_en, mem_w_r, mem_addr, mem_data_in);
        end
        testsRun++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h55AA0005) begin
            testsFailed++; $display("[TB] FAIL hold_rsp_stable: valid=%0b data=%0h want 1 55aa0005", rsp_valid, rsp_data);
        end
        nextCycle();
        #1;
        testsRun++;
        if (mem_en !== 1'b0 || rsp_valid !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL hold_third: en=%0b valid=%0b want 0 1", mem_en, rsp_valid);
        end
        nextCycle();
        rsp_ready = 1'b1;
        #1;
        testsRun++;
        if (rsp_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL hold_accept_cycle: valid=%0b want 1", rsp_valid); end
        nextCycle();
        #1;
        testsRun++;
        if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL hold_drop: valid=%0b idle=%0b want 0 1", rsp_valid, idle);
        end
    endtask

    task automatic test_err;
        int base;
        waitIdle();
        nextCycle();
        forceInvalid = 1'b1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd3;
        nextCycle();
        req_valid = 1'b0;
        nextCycle();
        forceInvalid = 1'b0;
        #1;
        testsRun++;
        if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_early: got %0b want 0", err); end
        nextCycle();
        #1;
        testsRun++;
        if (err !== 1'b1 || rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || rsp_addr !== 4'd3) begin
            testsFailed++; $display("[TB] FAIL err_set: err=%0b valid=%0b data=%0h addr=%0h want 1 1 deadbeef 3", err, rsp_valid, rsp_data, rsp_addr);
        end
        waitIdle();
        base = rspCount;
        nextCycle();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd5;
        nextCycle();
        req_valid = 1'b0;
        repeat (5) nextCycle();
        #3;
        testsRun++;
        if (err !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_sticky: got %0b want 1", err); end
        testsRun++;
        if (rspCount - base !== 1) begin
            testsFailed++; $display("[TB] FAIL err_next_rsp_count: got %0d want 1", rspCount - base);
        end else begin
            testsRun++;
            if (rspDataLog[base] !== 32'h55AA0005 || rspAddrLog[base] !== 4'd5) begin
                testsFailed++; $display("[TB] FAIL err_next_rsp: data=%0h addr=%0h want 55aa0005 5", rspDataLog[base], rspAddrLog[base]);
            end
        end
    endtask

    task automatic test_reset_in_rdwait;
        int base;
        waitIdle();
        base = rspCount;
        nextCycle();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd3;
        nextCycle();
        req_valid = 1'b0;
        #1;
        testsRun++;
        if (mem_en !== 1'b1 || mem_w_r !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL rst_pre_issue: en=%0b w_r=%0b want 1 0", mem_en, mem_w_r);
        end
        nextCycle();
        #3;
        RST = 1'b1;
        #1;
        testsRun++;
        if (req_ready !== 1'b0 || mem_en !== 1'b0 || rsp_valid !== 1'b0 || err !== 1'b0 || idle !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL rst_async: ready=%0b en=%0b valid=%0b err=%0b idle=%0b want 0 0 0 0 1", req_ready, mem_en, rsp_valid, err, idle);
        end
        testsRun++;
        if (rsp_data !== 32'd0 || rsp_addr !== 4'd0) begin
            testsFailed++; $display("[TB] FAIL rst_rsp_regs: data=%0h addr=%0h want 0 0", rsp_data, rsp_addr);
        end
        nextCycle();
        nextCycle();
        RST = 1'b0;
        #1;
        testsRun++;
        if (req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_release_ready: got %0b want 1", req_ready); end
        repeat (4) nextCycle();
        #3;
        testsRun++;
        if (rspCount !== base || rsp_valid !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL rst_no_rsp: responses=%0d valid=%0b want %0d 0", rspCount, rsp_valid, base);
        end
        nextCycle();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd0;
        nextCycle();
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rspCount > base) break;
            nextCycle();
        end
        #3;
        testsRun++;
        if (rspCount - base !== 1) begin
            testsFailed++; $display("[TB] FAIL rst_post_read_count: got %0d want 1", rspCount - base);
        end else begin
            testsRun++;
            if (rspDataLog[base] !== 32'd0 || rspAddrLog[base] !== 4'd0) begin
                testsFailed++; $display("[TB] FAIL rst_post_read: data=%0h addr=%0h want 0 0", rspDataLog[base], rspAddrLog[base]);
            end
        end
    endtask

    task automatic test_stream;
        int base;
        int idx;
        int budget;
        logic [31:0] expData;
        waitIdle();
        base = rspCount;
        idx = 0;
        budget = 0;
        while (idx < 10 && budget < 80) begin
            nextCycle();
            req_valid = 1'b1;
            req_wr    = (idx % 2 == 0);
            req_addr  = 4'(idx / 2);
            req_data  = 32'hA5000000 | (32'(idx / 2) << 8) | 32'(idx);
            #1;
            if (req_ready) idx++;
            budget++;
        end
        nextCycle();
        req_valid = 1'b0;
        testsRun++;
        if (idx !== 10) begin testsFailed++; $display("[TB] FAIL stream_accept: accepted %0d want 10", idx); end
        for (int i = 0; i < 60; i++) begin
            if (rspCount - base >= 5) break;
            nextCycle();
        end
        #3;
        testsRun++;
        if (rspCount - base !== 5) begin
            testsFailed++; $display("[TB] FAIL stream_rsp_count: got %0d want 5", rspCount - base);
        end else begin
            for (int j = 0; j < 5; j++) begin
                expData = 32'hA5000000 | (32'(j) << 8) | 32'(2 * j);
                testsRun++;
                if (rspAddrLog[base+j] !== 4'(j) || rspDataLog[base+j] !== expData) begin
                    testsFailed++; $display("[TB] FAIL stream_rsp%0d: addr=%0h data=%0h want %0h %0h", j, rspAddrLog[base+j], rspDataLog[base+j], j, expData);
                end
            end
        end
        testsRun++;
        if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL stream_err: got %0b want 0", err); end
    endtask

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        issCount      = 0;
        rspCount      = 0;
        forceInvalid  = 1'b0;
        mem_data_out  = 32'd0;
        mem_valid_out = 1'b0;
        for (int i = 0; i < 16; i++) memModel[i] = 32'd0;
        RST       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 4'd0;
        req_data  = 32'd0;
        rsp_ready = 1'b1;

        test_reset();
        test_write_read();
        test_fifo_full();
        test_rsp_hold_write();
        test_err();
        test_reset_in_rdwait();
        test_stream();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
